lr5_top_v10: RTL and testbench

//  Top of lab 5: 8x8 LED-matrix driver holding a 64-bit image register.
//  A 1 MHz clock-enable derived from the 48 MHz board clock scans one row per tick.
//  Two buttons shift the image by 4 bits right or left. RE selects rotate (wrap) or zero-fill.
//  The low 16 image bits are mirrored on the board LEDs.

---
 rtl/lr5_pkg.sv | 43 ++++
 rtl/lr5_if.sv | 24 ++
 rtl/lr5_btn_cond.sv | 77 +++++++
 rtl/lr5_top_v10.sv | 103 ++++++++++
 tb/tb_lr5_top_v10.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lr5_pkg.sv
// Shared constants, types and the nibble shifter for the lab 5 LED-matrix driver.
// Optional feature macro: LR5_DEBOUNCE_EN (button debounce in lr5_btn_cond).
package lr5_pkg;

  localparam int CLK_REF_DEF     = 48_000_000;
  localparam int CLK_CE_DEF      = 1_000_000;
  localparam int CLK_RELATE      = CLK_REF_DEF / CLK_CE_DEF;
  localparam int ROWS            = 8;
  localparam int COLS            = 8;
  localparam int NIBBLE          = 4;
  localparam int IMG_W           = ROWS * COLS;
  localparam int DEBOUNCE_CE_DEF = 16;
  localparam logic [IMG_W-1:0] INIT_PATTERN_DEF = 64'h0123_4567_89AB_CDEF;

  // Which shift, if any, is applied to the image this clock.
  typedef enum logic [1:0] {
    SH_NONE  = 2'd0,
    SH_RIGHT = 2'd1,
    SH_LEFT  = 2'd2
  } shift_op_e;

  // Shift the image by one nibble; re selects wrap-around versus zero fill.
  function automatic logic [IMG_W-1:0] shift_image(input logic [IMG_W-1:0] img,
                                                   input shift_op_e op,
                                                   input logic re);
    logic [NIBBLE-1:0] fill;
    logic [IMG_W-1:0]  res;
    res = img;
    case (op)
      SH_RIGHT: begin
        fill = re ? img[NIBBLE-1:0] : {NIBBLE{1'b0}};
        res  = {fill, img[IMG_W-1:NIBBLE]};
      end
      SH_LEFT: begin
        fill = re ? img[IMG_W-1:IMG_W-NIBBLE] : {NIBBLE{1'b0}};
        res  = {img[IMG_W-NIBBLE-1:0], fill};
      end
      default: res = img;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lr5_if.sv
// Board-facing signal bundle of the lab 5 driver: buttons, rotate select,
// matrix row/column drive and the LED mirror.
interface lr5_if;
  import lr5_pkg::*;

  logic              SHIFT_4B_R;
  logic              SHIFT_4B_L;
  logic              RE;
  logic [ROWS-1:0]   STRING;
  logic [COLS-1:0]   COLUMN;
  logic [15:0]       LED;

  // Board / stimulus side: drives buttons, observes the display.
  modport master (
    output SHIFT_4B_R, SHIFT_4B_L, RE,
    input  STRING, COLUMN, LED
  );

  // Driver side.
  modport slave (
    input  SHIFT_4B_R, SHIFT_4B_L, RE,
    output STRING, COLUMN, LED
  );
endinterface

// File: rtl/lr5_btn_cond.sv
// Button conditioner: 2-FF synchronizer, optional debounce filter, rising-edge pulse.
// With LR5_DEBOUNCE_EN defined the synchronized level must hold for DEBOUNCE_CE
// consecutive ce ticks before the filtered level follows it.
module lr5_btn_cond
  import lr5_pkg::*;
#(
  parameter int DEBOUNCE_CE = DEBOUNCE_CE_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic btn,
  output logic pulse
);

  logic sync1_reg;
  logic sync2_reg;
  logic filt;
  logic prev_reg;

  // Bring the asynchronous button into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

`ifdef LR5_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CE > 1) ? $clog2(DEBOUNCE_CE) : 1;

  logic [DB_W-1:0] db_cnt_reg;
  logic            level_reg;

  // Count ce ticks during which the input disagrees with the filtered level;
  // any return to agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_reg <= '0;
      level_reg  <= 1'b0;
    end else if (sync2_reg == level_reg) begin
      db_cnt_reg <= '0;
    end else if (ce) begin
      if (db_cnt_reg == DB_W'(DEBOUNCE_CE - 1)) begin
        level_reg  <= sync2_reg;
        db_cnt_reg <= '0;
      end else begin
        db_cnt_reg <= db_cnt_reg + 1'b1;
      end
    end
  end

  assign filt = level_reg;
`else
  // Without the filter the tick enable is not needed.
  logic unused_ce;
  localparam int unused_debounce_ce = DEBOUNCE_CE;
  assign unused_ce = ce;
  assign filt      = sync2_reg;
`endif

  // Remember the previous filtered level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg <= 1'b0;
    end else begin
      prev_reg <= filt;
    end
  end

  // One pulse per press: holding the button never repeats.
  assign pulse = filt & ~prev_reg;

endmodule

// File: rtl/lr5_top_v10.sv
// Lab 5 top: 8x8 LED-matrix driver with a 64-bit image register.
// A CE divider scans one row per tick, two buttons shift the image by a nibble,
// RE selects wrap or zero fill, and LED mirrors image[15:0].
// Optional feature macro: LR5_DEBOUNCE_EN (debounced buttons).
module lr5_top_v10
  import lr5_pkg::*;
#(
  parameter int               CLK_REF      = CLK_REF_DEF,
  parameter int               CLK_CE       = CLK_CE_DEF,
  parameter logic [IMG_W-1:0] INIT_PATTERN = INIT_PATTERN_DEF,
  parameter int               DEBOUNCE_CE  = DEBOUNCE_CE_DEF
) (
  input  logic clk,
  input  logic btnCpuReset,
  lr5_if.slave bus
);

  localparam int RELATE = CLK_REF / CLK_CE;
  localparam int CNT_W  = (RELATE > 1) ? $clog2(RELATE) : 1;
  localparam int ROW_W  = $clog2(ROWS);

  logic [CNT_W-1:0] ce_cnt_reg;
  logic             ce;
  logic [IMG_W-1:0] image_reg;
  logic [IMG_W-1:0] image_next;
  logic [ROW_W-1:0] row_reg;
  logic [ROW_W-1:0] row_next;
  logic [ROWS-1:0]  string_reg;
  logic [COLS-1:0]  column_reg;
  logic [1:0]       btn_raw;
  logic [1:0]       btn_pulse;
  shift_op_e        shift_op;

  // Tick-enable divider: one ce pulse every RELATE clocks.
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      ce_cnt_reg <= '0;
    end else if (ce) begin
      ce_cnt_reg <= '0;
    end else begin
      ce_cnt_reg <= ce_cnt_reg + 1'b1;
    end
  end

  assign ce = (ce_cnt_reg == CNT_W'(RELATE - 1));

  // Index 0 is the right-shift button, index 1 the left-shift button.
  assign btn_raw = {bus.SHIFT_4B_L, bus.SHIFT_4B_R};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    lr5_btn_cond #(
      .DEBOUNCE_CE(DEBOUNCE_CE)
    ) u_btn (
      .clk  (clk),
      .rst_n(btnCpuReset),
      .ce   (ce),
      .btn  (btn_raw[gi]),
      .pulse(btn_pulse[gi])
    );
  end

  // Decode the button pulses; simultaneous presses cancel out.
  always_comb begin
    shift_op = SH_NONE;
    case (btn_pulse)
      2'b01:   shift_op = SH_RIGHT;
      2'b10:   shift_op = SH_LEFT;
      default: shift_op = SH_NONE;
    endcase
  end

  assign image_next = shift_image(image_reg, shift_op, bus.RE);

  // Image register; RE is only looked at in the clock a shift happens.
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      image_reg <= INIT_PATTERN;
    end else begin
      image_reg <= image_next;
    end
  end

  assign row_next = row_reg + 1'b1;

  // Row scanner: advance one row per ce and latch that row's column byte.
  // Starting at row 7 makes the first tick after reset show row 0.
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      row_reg    <= ROW_W'(ROWS - 1);
      string_reg <= '0;
      column_reg <= '0;
    end else if (ce) begin
      row_reg    <= row_next;
      string_reg <= ROWS'(1) << row_next;
      column_reg <= image_reg[row_next*COLS +: COLS];
    end
  end

  assign bus.STRING = string_reg;
  assign bus.COLUMN = column_reg;
  assign bus.LED    = image_reg[15:0];

endmodule

// File: tb/tb_lr5_top_v10.sv
// Directed bench for lr5_top_v10 with a queue scoreboard of expected values.
// Also builds with LR5_DEBOUNCE_EN defined (longer presses, glitch test).
module tb_lr5_top_v10;

  localparam int RELATE = 48;

`ifdef LR5_DEBOUNCE_EN
  localparam int PRESS_HOLD = 20 * RELATE;
  localparam int SETTLE     = 19 * RELATE;
`else
  localparam int PRESS_HOLD = 4;
  localparam int SETTLE     = 4;
`endif

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  logic clk;
  logic rst_n;
  lr5_if bus ();

  lr5_top_v10 dut (
    .clk        (clk),
    .btnCpuReset(rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] model;
  logic [63:0] img;
  int          cl;

  function automatic logic [63:0] m_shr(input logic [63:0] v, input logic re);
    return {(re ? v[3:0] : 4'h0), v[63:4]};
  endfunction

  function automatic logic [63:0] m_shl(input logic [63:0] v, input logic re);
    return {v[59:0], (re ? v[63:60] : 4'h0)};
  endfunction

  task automatic push(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [63:0] obs);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  // Clocks until STRING changes (the next ce), bounded.
  task automatic wait_row_change(output int clks);
    logic [7:0] prev;
    logic       seen;
    prev = bus.STRING;
    seen = 1'b0;
    clks = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.STRING !== prev) begin
        seen = 1'b1;
        clks = i;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $error("FAIL row_timeout observed=no_ce expected=ce_within_200_clk");
    end
  endtask

  // Rebuild the full image from eight consecutive rows of the scan.
  task automatic scan_image(output logic [63:0] res);
    int c;
    int row;
    res = '0;
    for (int k = 0; k < 8; k++) begin
      wait_row_change(c);
      row = -1;
      for (int j = 0; j < 8; j++)
        if (bus.STRING === (8'h01 << j)) row = j;
      if (row < 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL string_onehot observed=%h expected=one_hot", bus.STRING);
      end else begin
        res[row*8 +: 8] = bus.COLUMN;
      end
    end
  endtask

  task automatic press(input logic r, input logic l);
    @(negedge clk);
    bus.SHIFT_4B_R = r;
    bus.SHIFT_4B_L = l;
    repeat (PRESS_HOLD) @(negedge clk);
    bus.SHIFT_4B_R = 1'b0;
    bus.SHIFT_4B_L = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  // Reset in the middle of a clock period and check the outputs at once.
  task automatic mid_reset();
    @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    push("rst_string", 64'h0);
    push("rst_column", 64'h0);
    push("rst_led", 64'hCDEF);
    pop_check(64'(bus.STRING));
    pop_check(64'(bus.COLUMN));
    pop_check(64'(bus.LED));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model = 64'h0123_4567_89AB_CDEF;
  endtask

  initial begin
    rst_n          = 1'b1;
    bus.SHIFT_4B_R = 1'b0;
    bus.SHIFT_4B_L = 1'b0;
    bus.RE         = 1'b0;
    model          = 64'h0123_4567_89AB_CDEF;

    // Power-on reset values.
    #3 rst_n = 1'b0;
    #1;
    push("por_string", 64'h0);
    push("por_column", 64'h0);
    push("por_led", 64'hCDEF);
    pop_check(64'(bus.STRING));
    pop_check(64'(bus.COLUMN));
    pop_check(64'(bus.LED));

    // Scan: first ce on the 48th clock shows row 0, then one row per 48 clk, wrapping.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 9; r++) begin
      push($sformatf("ce_gap_%0d", r), 64'(RELATE));
      push($sformatf("string_row%0d", r % 8), 64'(8'h01 << (r % 8)));
      push($sformatf("column_row%0d", r % 8), 64'(model[(r%8)*8 +: 8]));
    end
    for (int r = 0; r < 9; r++) begin
      wait_row_change(cl);
      pop_check(64'(cl));
      pop_check(64'(bus.STRING));
      pop_check(64'(bus.COLUMN));
    end
    push("idle_led", 64'hCDEF);
    pop_check(64'(bus.LED));

    // Held right button, zero fill: exactly one shift.
    bus.RE = 1'b0;
    model  = m_shr(model, 1'b0);
`ifndef LR5_DEBOUNCE_EN
    @(negedge clk);
    bus.SHIFT_4B_R = 1'b1;
    push("lat_edge1_led", 64'hCDEF);
    push("lat_edge2_led", 64'hCDEF);
    push("lat_edge3_led", 64'hBCDE);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      pop_check(64'(bus.LED));
    end
`else
    @(negedge clk);
    bus.SHIFT_4B_R = 1'b1;
`endif
    repeat (4800) @(negedge clk);
    push("hold_led", 64'hBCDE);
    pop_check(64'(bus.LED));
    bus.SHIFT_4B_R = 1'b0;
    repeat (SETTLE) @(negedge clk);
    push("hold_image", 64'h0012_3456_789A_BCDE);
    scan_image(img);
    pop_check(img);

    // Left shift with wrap from reset.
    mid_reset();
    bus.RE = 1'b1;
    press(1'b0, 1'b1);
    model = m_shl(model, 1'b1);
    push("shl_re_led", 64'hDEF0);
    pop_check(64'(bus.LED));
    push("shl_re_image", 64'h1234_5678_9ABC_DEF0);
    scan_image(img);
    pop_check(img);

    // Right shift with wrap; sixteen presses go all the way round.
    mid_reset();
    bus.RE = 1'b1;
    press(1'b1, 1'b0);
    model = m_shr(model, 1'b1);
    push("shr_re_led", 64'hBCDE);
    pop_check(64'(bus.LED));
    push("shr_re_image", 64'hF012_3456_789A_BCDE);
    scan_image(img);
    pop_check(img);
    for (int p = 2; p <= 16; p++) begin
      press(1'b1, 1'b0);
      model = m_shr(model, 1'b1);
      push($sformatf("rot_led_%0d", p), 64'(model[15:0]));
      pop_check(64'(bus.LED));
    end
    push("rot16_image", 64'h0123_4567_89AB_CDEF);
    scan_image(img);
    pop_check(img);

    // Both buttons together: no shift.
    press(1'b1, 1'b1);
    push("both_led", 64'(model[15:0]));
    pop_check(64'(bus.LED));
    push("both_image", model);
    scan_image(img);
    pop_check(img);

    // RE on its own changes nothing.
    @(negedge clk);
    bus.RE = 1'b0;
    repeat (10) @(negedge clk);
    bus.RE = 1'b1;
    repeat (10) @(negedge clk);
    push("re_only_led", 64'(model[15:0]));
    pop_check(64'(bus.LED));

    // Zero-fill left shift from a non-reset image.
    bus.RE = 1'b0;
    press(1'b0, 1'b1);
    model = m_shl(model, 1'b0);
    push("shl_zero_image", 64'h1234_5678_9ABC_DEF0);
    scan_image(img);
    pop_check(img);

`ifdef LR5_DEBOUNCE_EN
    // A 5-tick glitch is filtered out; a 20-tick press gives one shift.
    @(negedge clk);
    bus.SHIFT_4B_R = 1'b1;
    repeat (5 * RELATE) @(negedge clk);
    bus.SHIFT_4B_R = 1'b0;
    repeat (30 * RELATE) @(negedge clk);
    push("glitch_led", 64'(model[15:0]));
    pop_check(64'(bus.LED));
    press(1'b1, 1'b0);
    model = m_shr(model, 1'b0);
    push("debounced_image", model);
    scan_image(img);
    pop_check(img);
`endif

    // Final reset mid-scan returns to the reset values immediately.
    mid_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
